// File: rtl/prl_pkg.sv
// Shared encodings for the protocol-layer TX packer: message and SOP types,
// header field positions, result codes and FSM states.
package prl_pkg;

  localparam logic [1:0] MSG_CONTROL  = 2'd0;
  localparam logic [1:0] MSG_DATA     = 2'd1;
  localparam logic [1:0] MSG_EXTENDED = 2'd2;
  localparam logic [1:0] MSG_ILLEGAL  = 2'd3;

  localparam logic [2:0] SOP_SOP         = 3'd0;
  localparam logic [2:0] SOP_SOP_P       = 3'd1;
  localparam logic [2:0] SOP_SOP_PP      = 3'd2;
  localparam logic [2:0] SOP_ORDERED_MIN = 3'd3;

  localparam int HDR_TYPE_LSB  = 0;
  localparam int HDR_DROLE_BIT = 5;
  localparam int HDR_REV_LSB   = 6;
  localparam int HDR_PROLE_BIT = 8;
  localparam int HDR_ID_LSB    = 9;
  localparam int HDR_NDO_LSB   = 12;
  localparam int HDR_EXT_BIT   = 15;

  localparam logic [1:0] RESULT_SUCCESS  = 2'd0;
  localparam logic [1:0] RESULT_REJECTED = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HEADER     = 3'd1,
    ST_EXT_HEADER = 3'd2,
    ST_DATA       = 3'd3,
    ST_WAIT_DONE  = 3'd4
  } state_e;

  // Data-object count advertised for an extended message: the payload is the
  // 2-byte extended header plus ex_data_size bytes, rounded up to whole words.
  function automatic logic [2:0] ext_num_do(input logic [8:0] size);
    logic [9:0] words;
    words = ({1'b0, size} + 10'd5) >> 2;
    return (words > 10'd7) ? 3'd7 : words[2:0];
  endfunction

endpackage

// File: rtl/prl_tx_message_packer.sv
// USB PD protocol-layer TX packer: builds the message header (and extended
// header), then hands header and data objects to the PHY one byte per pull.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | waiting for a request from the protocol-layer TX FSM
// HEADER      | presenting the 2 message-header bytes
// EXT_HEADER  | presenting the 2 extended-header bytes
// DATA        | presenting data-object bytes, low byte first
// WAIT_DONE   | all bytes consumed (or ordered set only); waiting on PHY
module prl_tx_message_packer
  import prl_pkg::*;
#(
  parameter int MAX_EXT_BYTES = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prl_tx_req,
  input  logic [1:0]  prl_tx_message_type,
  input  logic [2:0]  prl_tx_sop_type,
  input  logic [4:0]  prl_tx_header_type,
  input  logic [2:0]  prl_tx_message_id,
  input  logic        prl_tx_data_role,
  input  logic        prl_tx_power_role,
  input  logic [1:0]  prl_tx_spec_rev,
  input  logic [2:0]  prl_tx_num_do,
  input  logic [8:0]  prl_tx_ex_data_size,
  output logic [2:0]  prl_tx_do_index,
  input  logic [31:0] prl_tx_do_data,
  output logic        prl2phy_tx_packet_en,
  output logic [2:0]  prl2phy_tx_packet_type,
  output logic [7:0]  prl2phy_tx_payload,
  output logic        prl2phy_tx_payload_last,
  input  logic        phy2prl_tx_payload_req,
  input  logic        phy2prl_tx_packet_done,
  input  logic [1:0]  phy2prl_tx_packet_result,
  output logic        prl_tx_busy,
  output logic        prl_tx_message_done,
  output logic [1:0]  prl_tx_message_result
);

  localparam logic [8:0] MAX_EXT = 9'(MAX_EXT_BYTES);

  state_e      state, state_next;
  logic [1:0]  msg_type_q;
  logic [15:0] header_q, ext_header_q;
  logic [5:0]  data_len_q;
  logic [4:0]  pos_q;
  logic        req_illegal, accept, reject, advance;
  logic [2:0]  num_do_field;
  logic [15:0] header_next, ext_header_next;
  logic [5:0]  data_len_next;

  // Request legality, header/extended-header assembly and payload length.
  always_comb begin
    req_illegal = (prl_tx_message_type == MSG_ILLEGAL) ||
                  (prl_tx_message_type == MSG_DATA && prl_tx_num_do == 3'd0) ||
                  (prl_tx_message_type == MSG_EXTENDED &&
                   (prl_tx_ex_data_size == 9'd0 || prl_tx_ex_data_size > MAX_EXT));
    num_do_field = 3'd0;
    if (prl_tx_message_type == MSG_DATA) num_do_field = prl_tx_num_do;
    else if (prl_tx_message_type == MSG_EXTENDED) num_do_field = ext_num_do(prl_tx_ex_data_size);
    header_next = '0;
    header_next[HDR_TYPE_LSB +: 5] = prl_tx_header_type;
    header_next[HDR_DROLE_BIT]     = prl_tx_data_role;
    header_next[HDR_REV_LSB +: 2]  = prl_tx_spec_rev;
    header_next[HDR_PROLE_BIT]     = prl_tx_power_role;
    header_next[HDR_ID_LSB +: 3]   = prl_tx_message_id;
    header_next[HDR_NDO_LSB +: 3]  = num_do_field;
    header_next[HDR_EXT_BIT]       = (prl_tx_message_type == MSG_EXTENDED);
    // chunked=1, chunk 0, no chunk request, reserved 0
    ext_header_next = {1'b1, 4'd0, 1'b0, 1'b0, prl_tx_ex_data_size};
    data_len_next = (prl_tx_message_type == MSG_EXTENDED) ? prl_tx_ex_data_size[5:0]
                                                          : {1'b0, prl_tx_num_do, 2'b00};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state, byte mux and last-byte flag.
  always_comb begin
    state_next              = state;
    accept                  = 1'b0;
    reject                  = 1'b0;
    advance                 = 1'b0;
    prl2phy_tx_payload      = 8'd0;
    prl2phy_tx_payload_last = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (prl_tx_req) begin
          if (req_illegal) reject = 1'b1;
          else begin
            accept     = 1'b1;
            state_next = (prl_tx_sop_type >= SOP_ORDERED_MIN) ? ST_WAIT_DONE : ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        prl2phy_tx_payload      = pos_q[0] ? header_q[15:8] : header_q[7:0];
        prl2phy_tx_payload_last = (msg_type_q == MSG_CONTROL) && pos_q[0];
        if (phy2prl_tx_payload_req) begin
          advance = 1'b1;
          if (pos_q[0]) begin
            if (msg_type_q == MSG_EXTENDED)  state_next = ST_EXT_HEADER;
            else if (msg_type_q == MSG_DATA) state_next = ST_DATA;
            else                             state_next = ST_WAIT_DONE;
          end
        end
      end
      ST_EXT_HEADER: begin
        prl2phy_tx_payload = pos_q[0] ? ext_header_q[15:8] : ext_header_q[7:0];
        if (phy2prl_tx_payload_req) begin
          advance = 1'b1;
          if (pos_q[0]) state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        unique case (pos_q[1:0])
          2'd0: prl2phy_tx_payload = prl_tx_do_data[7:0];
          2'd1: prl2phy_tx_payload = prl_tx_do_data[15:8];
          2'd2: prl2phy_tx_payload = prl_tx_do_data[23:16];
          default: prl2phy_tx_payload = prl_tx_do_data[31:24];
        endcase
        prl2phy_tx_payload_last = ({1'b0, pos_q} == data_len_q - 6'd1);
        if (phy2prl_tx_payload_req) begin
          advance = 1'b1;
          if (prl2phy_tx_payload_last) state_next = ST_WAIT_DONE;
        end
      end
      default: ;
    endcase
    // PHY completion (or abort) ends the message from any active state.
    if (state != ST_IDLE && phy2prl_tx_packet_done) state_next = ST_IDLE;
  end

  // Request capture; byte position restarts at every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_type_q             <= MSG_CONTROL;
      header_q               <= '0;
      ext_header_q           <= '0;
      data_len_q             <= '0;
      pos_q                  <= '0;
      prl2phy_tx_packet_type <= '0;
    end else begin
      if (accept) begin
        msg_type_q             <= prl_tx_message_type;
        header_q               <= header_next;
        ext_header_q           <= ext_header_next;
        data_len_q             <= data_len_next;
        prl2phy_tx_packet_type <= prl_tx_sop_type;
      end
      if (state_next != state) pos_q <= '0;
      else if (advance)        pos_q <= pos_q + 5'd1;
    end
  end

  // Start pulse to the PHY and completion pulse/result upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prl2phy_tx_packet_en  <= 1'b0;
      prl_tx_message_done   <= 1'b0;
      prl_tx_message_result <= RESULT_SUCCESS;
    end else begin
      prl2phy_tx_packet_en <= accept;
      prl_tx_message_done  <= 1'b0;
      if (reject) begin
        prl_tx_message_done   <= 1'b1;
        prl_tx_message_result <= RESULT_REJECTED;
      end else if (state != ST_IDLE && phy2prl_tx_packet_done) begin
        prl_tx_message_done   <= 1'b1;
        prl_tx_message_result <= phy2prl_tx_packet_result;
      end
    end
  end

  assign prl_tx_busy     = (state != ST_IDLE);
  assign prl_tx_do_index = (state == ST_DATA) ? pos_q[4:2] : 3'd0;

endmodule

// File: tb/tb_prl_tx_message_packer.sv
// Scoreboard bench for the TX packer: stimulus pushes expected bytes, start
// types and results; a negedge monitor pops and compares as the DUT presents them.
module tb_prl_tx_message_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prl_tx_req = 1'b0;
  logic [1:0]  prl_tx_message_type = '0;
  logic [2:0]  prl_tx_sop_type = '0;
  logic [4:0]  prl_tx_header_type = '0;
  logic [2:0]  prl_tx_message_id = '0;
  logic        prl_tx_data_role = 1'b0;
  logic        prl_tx_power_role = 1'b0;
  logic [1:0]  prl_tx_spec_rev = '0;
  logic [2:0]  prl_tx_num_do = '0;
  logic [8:0]  prl_tx_ex_data_size = '0;
  logic [2:0]  prl_tx_do_index;
  logic [31:0] prl_tx_do_data;
  logic        prl2phy_tx_packet_en;
  logic [2:0]  prl2phy_tx_packet_type;
  logic [7:0]  prl2phy_tx_payload;
  logic        prl2phy_tx_payload_last;
  logic        phy2prl_tx_payload_req = 1'b0;
  logic        phy2prl_tx_packet_done = 1'b0;
  logic [1:0]  phy2prl_tx_packet_result = '0;
  logic        prl_tx_busy;
  logic        prl_tx_message_done;
  logic [1:0]  prl_tx_message_result;

  logic [31:0] do_mem [8];
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_bytes [$];
  logic [2:0] exp_en    [$];
  logic [1:0] exp_done  [$];

  assign prl_tx_do_data = do_mem[prl_tx_do_index];

  always #5 clk = ~clk;

  prl_tx_message_packer #(.MAX_EXT_BYTES(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .prl_tx_req(prl_tx_req), .prl_tx_message_type(prl_tx_message_type),
    .prl_tx_sop_type(prl_tx_sop_type), .prl_tx_header_type(prl_tx_header_type),
    .prl_tx_message_id(prl_tx_message_id), .prl_tx_data_role(prl_tx_data_role),
    .prl_tx_power_role(prl_tx_power_role), .prl_tx_spec_rev(prl_tx_spec_rev),
    .prl_tx_num_do(prl_tx_num_do), .prl_tx_ex_data_size(prl_tx_ex_data_size),
    .prl_tx_do_index(prl_tx_do_index), .prl_tx_do_data(prl_tx_do_data),
    .prl2phy_tx_packet_en(prl2phy_tx_packet_en), .prl2phy_tx_packet_type(prl2phy_tx_packet_type),
    .prl2phy_tx_payload(prl2phy_tx_payload), .prl2phy_tx_payload_last(prl2phy_tx_payload_last),
    .phy2prl_tx_payload_req(phy2prl_tx_payload_req), .phy2prl_tx_packet_done(phy2prl_tx_packet_done),
    .phy2prl_tx_packet_result(phy2prl_tx_packet_result), .prl_tx_busy(prl_tx_busy),
    .prl_tx_message_done(prl_tx_message_done), .prl_tx_message_result(prl_tx_message_result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  // Monitor: compare every byte the PHY pulls, every start pulse and every done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (phy2prl_tx_payload_req) begin
        if (exp_bytes.size() == 0) unexpected("byte", {prl2phy_tx_payload_last, prl2phy_tx_payload});
        else check("byte", {prl2phy_tx_payload_last, prl2phy_tx_payload}, exp_bytes.pop_front());
      end
      if (prl2phy_tx_packet_en) begin
        if (exp_en.size() == 0) unexpected("packet_en", prl2phy_tx_packet_type);
        else check("packet_type", prl2phy_tx_packet_type, exp_en.pop_front());
      end
      if (prl_tx_message_done) begin
        if (exp_done.size() == 0) unexpected("message_done", prl_tx_message_result);
        else check("message_result", prl_tx_message_result, exp_done.pop_front());
      end
    end
  end

  task automatic send_req(input logic [1:0] mt, input logic [2:0] sop, input logic [4:0] ht,
                          input logic [2:0] id, input logic dr, input logic pr,
                          input logic [1:0] rev, input logic [2:0] ndo, input logic [8:0] sz);
    prl_tx_message_type = mt;  prl_tx_sop_type = sop; prl_tx_header_type = ht;
    prl_tx_message_id = id;    prl_tx_data_role = dr; prl_tx_power_role = pr;
    prl_tx_spec_rev = rev;     prl_tx_num_do = ndo;   prl_tx_ex_data_size = sz;
    prl_tx_req = 1'b1;
    @(posedge clk); #1;
    prl_tx_req = 1'b0;
  endtask

  task automatic pull(input int n);
    for (int i = 0; i < n; i++) begin
      phy2prl_tx_payload_req = 1'b1;
      @(posedge clk); #1;
    end
    phy2prl_tx_payload_req = 1'b0;
  endtask

  task automatic phy_done(input logic [1:0] r);
    phy2prl_tx_packet_done = 1'b1;
    phy2prl_tx_packet_result = r;
    @(posedge clk); #1;
    phy2prl_tx_packet_done = 1'b0;
    phy2prl_tx_packet_result = 2'd0;
  endtask

  task automatic push_bytes(input logic [15:0] w, input logic last_hi);
    exp_bytes.push_back({1'b0, w[7:0]});
    exp_bytes.push_back({last_hi, w[15:8]});
  endtask

  initial begin
    for (int i = 0; i < 8; i++) do_mem[i] = 32'd0;
    #12;
    check("reset_busy", prl_tx_busy, 0);
    check("reset_outputs", {prl2phy_tx_packet_en, prl2phy_tx_packet_type, prl2phy_tx_payload,
                            prl2phy_tx_payload_last, prl_tx_message_done, prl_tx_message_result,
                            prl_tx_do_index}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // GoodCRC: type 1, id 3, rev 2, power role 1 -> header 0x0781
    exp_en.push_back(3'd0);
    push_bytes(16'h0781, 1'b1);
    send_req(2'd0, 3'd0, 5'd1, 3'd3, 1'b0, 1'b1, 2'd2, 3'd0, 9'd0);
    @(negedge clk);
    check("goodcrc_en_n1", prl2phy_tx_packet_en, 1);
    check("goodcrc_first_byte_n1", prl2phy_tx_payload, 8'h81);
    @(posedge clk); #1;
    pull(2);
    @(negedge clk);
    check("goodcrc_wait_done_busy", prl_tx_busy, 1);
    check("goodcrc_wait_done_last", prl2phy_tx_payload_last, 0);
    @(posedge clk); #1;
    exp_done.push_back(2'd0);
    phy_done(2'd0);
    @(negedge clk);
    check("goodcrc_idle_after_done", prl_tx_busy, 0);
    @(posedge clk); #1;

    // Data message, 1 DO: type 2, id 1, rev 2 -> header 0x1282
    do_mem[0] = 32'h1304B12C;
    exp_en.push_back(3'd1);
    push_bytes(16'h1282, 1'b0);
    push_bytes(16'hB12C, 1'b0);
    push_bytes(16'h1304, 1'b1);
    send_req(2'd1, 3'd1, 5'd2, 3'd1, 1'b0, 1'b0, 2'd2, 3'd1, 9'd0);
    pull(6);
    @(negedge clk);
    check("data_do_index_wait", prl_tx_do_index, 0);
    @(posedge clk); #1;
    // an illegal request while busy must be ignored (no extra done)
    send_req(2'd3, 3'd0, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 9'd0);
    check("data_busy_after_ignored_req", prl_tx_busy, 1);
    exp_done.push_back(2'd0);
    phy_done(2'd0);

    // Extended, 5 bytes: type 0x0C, id 2, rev 2, data role 1 -> 0xA4AC, ext 0x8005
    do_mem[0] = 32'h44332211;
    do_mem[1] = 32'h88776655;
    exp_en.push_back(3'd2);
    push_bytes(16'hA4AC, 1'b0);
    push_bytes(16'h8005, 1'b0);
    push_bytes(16'h2211, 1'b0);
    push_bytes(16'h4433, 1'b0);
    exp_bytes.push_back({1'b1, 8'h55});
    send_req(2'd2, 3'd2, 5'h0C, 3'd2, 1'b1, 1'b0, 2'd2, 3'd0, 9'd5);
    pull(9);
    @(negedge clk);
    check("ext5_wait_done", prl_tx_busy, 1);
    @(posedge clk); #1;
    exp_done.push_back(2'd1);
    phy_done(2'd1);

    // Extended, 26 bytes (largest legal): header 0xF081, ext 0x801A, bytes 0..25
    for (int i = 0; i < 8; i++)
      do_mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    exp_en.push_back(3'd0);
    push_bytes(16'hF081, 1'b0);
    push_bytes(16'h801A, 1'b0);
    for (int k = 0; k < 26; k++) exp_bytes.push_back({(k == 25), 8'(k)});
    send_req(2'd2, 3'd0, 5'd1, 3'd0, 1'b0, 1'b0, 2'd2, 3'd0, 9'd26);
    pull(30);
    exp_done.push_back(2'd0);
    phy_done(2'd0);

    // Hard reset: ordered set only, no payload
    exp_en.push_back(3'd3);
    send_req(2'd0, 3'd3, 5'd0, 3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 9'd0);
    @(negedge clk);
    check("hardreset_en", prl2phy_tx_packet_en, 1);
    check("hardreset_no_last", prl2phy_tx_payload_last, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("hardreset_busy", prl_tx_busy, 1);
    @(posedge clk); #1;
    exp_done.push_back(2'd0);
    phy_done(2'd0);

    // Abort after one header byte: data, 2 DOs, type 1, id 5, rev 1 -> 0x2A41
    exp_en.push_back(3'd0);
    exp_bytes.push_back({1'b0, 8'h41});
    send_req(2'd1, 3'd0, 5'd1, 3'd5, 1'b0, 1'b0, 2'd1, 3'd2, 9'd0);
    pull(1);
    exp_done.push_back(2'd2);
    phy_done(2'd2);
    @(negedge clk);
    check("abort_idle", prl_tx_busy, 0);
    check("abort_no_payload", {prl2phy_tx_payload_last, prl2phy_tx_payload}, 0);
    @(posedge clk); #1;

    // Rejections: data with 0 DOs, extended size 27, extended size 0, type 3
    exp_done.push_back(2'd3);
    send_req(2'd1, 3'd0, 5'd1, 3'd0, 1'b0, 1'b0, 2'd2, 3'd0, 9'd0);
    @(negedge clk);
    check("reject_ndo0_done_n1", {prl_tx_message_done, prl2phy_tx_packet_en, prl_tx_busy}, 3'b100);
    @(posedge clk); #1;
    exp_done.push_back(2'd3);
    send_req(2'd2, 3'd0, 5'd1, 3'd0, 1'b0, 1'b0, 2'd2, 3'd0, 9'd27);
    @(negedge clk);
    check("reject_ext27_done_n1", {prl_tx_message_done, prl2phy_tx_packet_en, prl_tx_busy}, 3'b100);
    @(posedge clk); #1;
    exp_done.push_back(2'd3);
    send_req(2'd2, 3'd0, 5'd1, 3'd0, 1'b0, 1'b0, 2'd2, 3'd0, 9'd0);
    exp_done.push_back(2'd3);
    send_req(2'd3, 3'd0, 5'd1, 3'd0, 1'b0, 1'b0, 2'd2, 3'd0, 9'd0);
    @(posedge clk); #1;

    // Reset mid-packet: transfer dropped, no done pulse
    exp_en.push_back(3'd1);
    exp_bytes.push_back({1'b0, 8'h41});
    send_req(2'd1, 3'd1, 5'd1, 3'd5, 1'b0, 1'b0, 2'd1, 3'd2, 9'd0);
    pull(1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {prl_tx_busy, prl2phy_tx_packet_type, prl2phy_tx_payload,
                               prl_tx_message_done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    check("leftover_bytes", exp_bytes.size(), 0);
    check("leftover_packet_en", exp_en.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
